exec_monitor: RTL and testbench

//   Synthesizable run-control monitor beside the ternary CPU in system. Once armed, it:
//   - counts cycles and retired instructions;
//   - declares halt when the PC is stuck in FETCH for STALL_CYCLES consecutive cycles;
//   - declares timeout after TIMEOUT_CYCLES;
//   - captures CPU memory writes in a drainable trace FIFO.

---
 rtl/exec_monitor_pkg.sv | 19 +
 rtl/exec_monitor_if.sv | 38 +++
 rtl/exec_monitor_trace_fifo.sv | 70 +++++++
 rtl/exec_monitor.sv | 117 +++++++++++
 tb/tb_exec_monitor.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_monitor_pkg.sv
// Shared types and constants for the CPU run-control monitor.
// Holds the monitor FSM encoding, the CPU state codes it watches and a saturating increment.
package exec_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  localparam int FETCH_STATE = 0;
  localparam int WB_STATE    = 4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/exec_monitor_if.sv
// Bundle of CPU observation, trace drain and status signals between the system and the monitor.
// The system (master) drives start/CPU/pop; the monitor (slave) drives trace and status.
interface exec_monitor_if #(
  parameter int ADDR_W  = 18,
  parameter int WORD_W  = 18,
  parameter int STATE_W = 3
);
  logic                      start;
  logic [ADDR_W-1:0]         cpu_pc;
  logic [STATE_W-1:0]        cpu_state;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [WORD_W-1:0]         mem_wdata;
  logic                      trace_pop;
  logic                      trace_valid;
  logic [ADDR_W-1:0]         trace_addr;
  logic [WORD_W-1:0]         trace_data;
  logic                      trace_overflow;
  logic                      busy;
  logic                      halted;
  logic                      timed_out;
  logic [31:0]               cycle_count;
  logic [31:0]               instr_count;
  exec_monitor_pkg::mon_state_t dbg_state;

  // Trace drain: an entry is consumed on a cycle where trace_pop && trace_valid.
  modport master (
    output start, cpu_pc, cpu_state, mem_write, mem_addr, mem_wdata, trace_pop,
    input  trace_valid, trace_addr, trace_data, trace_overflow,
           busy, halted, timed_out, cycle_count, instr_count, dbg_state
  );

  modport slave (
    input  start, cpu_pc, cpu_state, mem_write, mem_addr, mem_wdata, trace_pop,
    output trace_valid, trace_addr, trace_data, trace_overflow,
           busy, halted, timed_out, cycle_count, instr_count, dbg_state
  );
endinterface

// File: rtl/exec_monitor_trace_fifo.sv
// First-word fall-through FIFO for captured memory writes, with a sticky drop flag.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear && !reset) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout     = mem_q[rd_ptr_q[AW-1:0]];
  assign valid    = !empty;
  assign overflow = ovf_q;

endmodule

// File: rtl/exec_monitor.sv
// Run-control monitor: counts cycles/retirements, detects a stuck-PC halt or a cycle
// budget timeout, and captures CPU memory writes into a drainable trace FIFO.
module exec_monitor
  import exec_monitor_pkg::*;
#(
  parameter int WORD_W         = 18,
  parameter int ADDR_W         = 18,
  parameter int STATE_W        = 3,
  parameter int STALL_CYCLES   = 5,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic          clock,
  input  logic          reset,
  exec_monitor_if.slave bus
);
  localparam int SW = $clog2(STALL_CYCLES + 1);

  mon_state_t        state_q, state_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       instr_q, instr_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
  logic              prev_valid_q, prev_valid_d;
  logic              run_active;
  logic              halt_hit;
  logic              timeout_hit;
  logic              fifo_full;

  assign run_active = (state_q == RUN) && !bus.start;

  // Counters and stall detector; start clears everything and takes priority.
  always_comb begin
    cycle_d      = cycle_q;
    instr_d      = instr_q;
    stall_d      = stall_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    if (bus.start) begin
      cycle_d      = '0;
      instr_d      = '0;
      stall_d      = '0;
      prev_valid_d = 1'b0;
    end else if (state_q == RUN) begin
      cycle_d = sat_inc32(cycle_q);
      if (bus.cpu_state == STATE_W'(WB_STATE)) instr_d = sat_inc32(instr_q);
      if ((bus.cpu_state == STATE_W'(FETCH_STATE)) && prev_valid_q && (bus.cpu_pc == prev_pc_q))
        stall_d = stall_q + 1'b1;
      else
        stall_d = '0;
      prev_pc_d    = bus.cpu_pc;
      prev_valid_d = 1'b1;
    end
  end

  assign halt_hit    = run_active && (stall_d == SW'(STALL_CYCLES));
  assign timeout_hit = run_active && (cycle_d == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt outranks timeout when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.start)        state_d = RUN;
    else if (halt_hit)    state_d = HALTED;
    else if (timeout_hit) state_d = TIMEOUT;
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.halted    = (state_q == HALTED);
    bus.timed_out = (state_q == TIMEOUT);
    bus.dbg_state = state_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q      <= '0;
      instr_q      <= '0;
      stall_q      <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      instr_q      <= instr_d;
      stall_q      <= stall_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;

  trace_fifo #(
    .WIDTH (ADDR_W + WORD_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clock    (clock),
    .reset    (reset),
    .clear    (bus.start),
    .push     (bus.mem_write && run_active),
    .pop      (bus.trace_pop),
    .din      ({bus.mem_addr, bus.mem_wdata}),
    .dout     ({bus.trace_addr, bus.trace_data}),
    .valid    (bus.trace_valid),
    .full     (fifo_full),
    .overflow (bus.trace_overflow)
  );

endmodule

// File: tb/tb_exec_monitor.sv
// Self-checking bench for exec_monitor: directed scenarios plus a randomized run
// compared every cycle against a queue-based reference model.
module tb_exec_monitor;
  import exec_monitor_pkg::*;

  localparam int ADDR_W = 18;
  localparam int WORD_W = 18;
  localparam int STATE_W = 3;
  localparam int STALL = 5;
  localparam int TMO = 100;
  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_TMO = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  exec_monitor_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .STATE_W(STATE_W)) bus();

  exec_monitor #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .STATE_W(STATE_W),
    .STALL_CYCLES(STALL), .TIMEOUT_CYCLES(TMO), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: run phase, counts, length of the current stuck-PC stretch, trace queue.
  int                            m_state = M_IDLE;
  longint unsigned               m_cycles = 0;
  longint unsigned               m_instr = 0;
  int                            m_hold = 0;
  bit                            m_have_prev = 0;
  logic [ADDR_W-1:0]             m_prev_pc = '0;
  bit                            m_ovf = 0;
  logic [ADDR_W+WORD_W-1:0]      exp_q[$];

  task automatic idle_inputs();
    bus.start = 0; bus.cpu_pc = '0; bus.cpu_state = 3'd1; bus.mem_write = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.trace_pop = 0;
  endtask

  task automatic model_clear();
    m_cycles = 0; m_instr = 0; m_hold = 0; m_have_prev = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // One clock: the model consumes the inputs that the DUT samples at this edge.
  task automatic step();
    bit pop_ok;
    bit push_req;
    @(posedge clock);
    if (reset) begin
      m_state = M_IDLE; model_clear();
    end else if (bus.start) begin
      m_state = M_RUN; model_clear();
    end else begin
      pop_ok   = bus.trace_pop && (exp_q.size() > 0);
      push_req = (m_state == M_RUN) && bus.mem_write;
      if (pop_ok) void'(exp_q.pop_front());
      if (push_req) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({bus.mem_addr, bus.mem_wdata});
        else m_ovf = 1;
      end
      if (m_state == M_RUN) begin
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        if (bus.cpu_state == 3'd4 && m_instr < 64'hFFFF_FFFF) m_instr++;
        if (bus.cpu_state == 3'd0 && m_have_prev && bus.cpu_pc == m_prev_pc) m_hold++;
        else m_hold = 0;
        m_have_prev = 1; m_prev_pc = bus.cpu_pc;
        if (m_hold >= STALL) m_state = M_HALT;
        else if (m_cycles >= TMO) m_state = M_TMO;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_start();
    bus.start = 1; step(); bus.start = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1;
    step(); step();
    reset = 0;
    n_checks += 8;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got=%b want=0", bus.halted); end
    if (bus.timed_out !== 1'b0) begin n_errors++; $display("FAIL reset_timed_out got=%b want=0", bus.timed_out); end
    if (bus.trace_valid !== 1'b0) begin n_errors++; $display("FAIL reset_trace_valid got=%b want=0", bus.trace_valid); end
    if (bus.trace_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got=%b want=0", bus.trace_overflow); end
    if (bus.cycle_count !== 32'd0) begin n_errors++; $display("FAIL reset_cycle got=%0d want=0", bus.cycle_count); end
    if (bus.instr_count !== 32'd0) begin n_errors++; $display("FAIL reset_instr got=%0d want=0", bus.instr_count); end
    if (bus.dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state got=%0d want=0", bus.dbg_state); end
  endtask

  task automatic test_halt();
    int first_k;
    logic [31:0] frozen;
    idle_inputs(); do_start();
    for (int p = 0; p < 9; p++) begin
      bus.cpu_pc = 18'(p); bus.cpu_state = 3'(p % 5); step();
    end
    bus.cpu_pc = 18'd9; bus.cpu_state = 3'd0;
    first_k = 0;
    for (int k = 1; k <= 12 && first_k == 0; k++) begin
      step();
      if (bus.halted === 1'b1) first_k = k;
    end
    n_checks += 4;
    if (first_k != 6) begin n_errors++; $display("FAIL halt_latency got=%0d want=6", first_k); end
    if (bus.cycle_count !== 32'(m_cycles)) begin n_errors++; $display("FAIL halt_cycle got=%0d want=%0d", bus.cycle_count, m_cycles); end
    if (bus.instr_count !== 32'(m_instr)) begin n_errors++; $display("FAIL halt_instr got=%0d want=%0d", bus.instr_count, m_instr); end
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL halt_busy got=%b want=0", bus.busy); end
    frozen = 32'(m_cycles);
    bus.mem_write = 1;
    step(); step(); step();
    bus.mem_write = 0;
    n_checks += 3;
    if (bus.cycle_count !== frozen) begin n_errors++; $display("FAIL halt_frozen got=%0d want=%0d", bus.cycle_count, frozen); end
    if (bus.halted !== 1'b1) begin n_errors++; $display("FAIL halt_hold got=%b want=1", bus.halted); end
    if (bus.trace_valid !== 1'b0) begin n_errors++; $display("FAIL halt_write_ignored got=%b want=0", bus.trace_valid); end
  endtask

  task automatic test_timeout();
    int seen;
    idle_inputs(); do_start();
    bus.cpu_state = 3'd0;
    seen = 0;
    for (int k = 1; k <= 120 && seen == 0; k++) begin
      bus.cpu_pc = 18'(k & 1); step();
      if (bus.timed_out === 1'b1) seen = k;
    end
    n_checks += 3;
    if (seen != TMO) begin n_errors++; $display("FAIL timeout_latency got=%0d want=%0d", seen, TMO); end
    if (bus.cycle_count !== 32'(TMO)) begin n_errors++; $display("FAIL timeout_cycle got=%0d want=%0d", bus.cycle_count, TMO); end
    if (bus.halted !== 1'b0) begin n_errors++; $display("FAIL timeout_halted got=%b want=0", bus.halted); end
  endtask

  task automatic test_overflow();
    idle_inputs(); do_start();
    for (int i = 0; i < 10; i++) begin
      bus.cpu_pc = 18'(100 + i); bus.mem_write = 1;
      bus.mem_addr = 18'(i); bus.mem_wdata = 18'(3 * i); step();
    end
    bus.mem_write = 0;
    n_checks++;
    if (bus.trace_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got=%b want=1", bus.trace_overflow); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.trace_valid !== 1'b1 || bus.trace_addr !== 18'(i) || bus.trace_data !== 18'(3 * i)) begin
        n_errors++;
        $display("FAIL ovf_pop%0d got=(%0d,%0d,v%b) want=(%0d,%0d)", i, bus.trace_addr, bus.trace_data, bus.trace_valid, i, 3 * i);
      end
      bus.cpu_pc = 18'(200 + i); bus.trace_pop = 1; step();
    end
    bus.trace_pop = 0;
    n_checks++;
    if (bus.trace_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained got=%b want=0", bus.trace_valid); end
  endtask

  task automatic test_full_push_pop();
    int k;
    idle_inputs(); do_start();
    for (int i = 0; i < DEPTH; i++) begin
      bus.cpu_pc = 18'(i); bus.mem_write = 1;
      bus.mem_addr = 18'($urandom); bus.mem_wdata = 18'($urandom); step();
    end
    bus.cpu_pc = 18'(50); bus.mem_addr = 18'h2AAAA; bus.mem_wdata = 18'h15555; bus.trace_pop = 1;
    step();
    bus.mem_write = 0; bus.trace_pop = 0;
    n_checks += 2;
    if (bus.trace_overflow !== 1'b0) begin n_errors++; $display("FAIL full_pp_ovf got=%b want=0", bus.trace_overflow); end
    if (exp_q.size() != DEPTH || exp_q[DEPTH-1] !== {18'h2AAAA, 18'h15555}) begin
      n_errors++; $display("FAIL full_pp_model size=%0d want=%0d", exp_q.size(), DEPTH);
    end
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      n_checks++;
      if (bus.trace_valid !== 1'b1 || {bus.trace_addr, bus.trace_data} !== exp_q[0]) begin
        n_errors++; $display("FAIL full_pp_drain%0d got=%h want=%h", k, {bus.trace_addr, bus.trace_data}, exp_q[0]);
      end
      bus.cpu_pc = 18'(60 + k); bus.trace_pop = 1; step(); k++;
    end
    bus.trace_pop = 0;
    // Empty FIFO with push and pop together: push lands, pop ignored.
    bus.cpu_pc = 18'(90); bus.mem_write = 1; bus.trace_pop = 1;
    bus.mem_addr = 18'h00123; bus.mem_wdata = 18'h00456; step();
    bus.mem_write = 0; bus.trace_pop = 0;
    n_checks++;
    if (bus.trace_valid !== 1'b1 || bus.trace_addr !== 18'h00123 || bus.trace_data !== 18'h00456) begin
      n_errors++; $display("FAIL empty_pp got=(%h,%h,v%b) want=(123,456)", bus.trace_addr, bus.trace_data, bus.trace_valid);
    end
  endtask

  task automatic test_reset_start_mid_run();
    idle_inputs(); do_start();
    for (int i = 0; i < 5; i++) begin
      bus.cpu_pc = 18'(i); bus.cpu_state = 3'd4; bus.mem_write = 1; bus.mem_addr = 18'(i); step();
    end
    reset = 1; step(); reset = 0;
    n_checks += 4;
    if (bus.dbg_state !== IDLE) begin n_errors++; $display("FAIL midrst_state got=%0d want=0", bus.dbg_state); end
    if (bus.cycle_count !== 32'd0 || bus.instr_count !== 32'd0) begin
      n_errors++; $display("FAIL midrst_counts got=%0d/%0d want=0/0", bus.cycle_count, bus.instr_count);
    end
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    step();
    if (bus.trace_valid !== 1'b0) begin n_errors++; $display("FAIL idle_write_ignored got=%b want=0", bus.trace_valid); end
    do_start();
    for (int i = 0; i < 4; i++) begin
      bus.cpu_pc = 18'(10 + i); bus.mem_addr = 18'(i); step();
    end
    bus.start = 1; step(); bus.start = 0; bus.mem_write = 0;
    n_checks += 4;
    if (bus.cycle_count !== 32'd0 || bus.instr_count !== 32'd0) begin
      n_errors++; $display("FAIL midstart_counts got=%0d/%0d want=0/0", bus.cycle_count, bus.instr_count);
    end
    if (bus.trace_valid !== 1'b0) begin n_errors++; $display("FAIL midstart_fifo got=%b want=0", bus.trace_valid); end
    if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL midstart_busy got=%b want=1", bus.busy); end
    if (bus.trace_overflow !== 1'b0) begin n_errors++; $display("FAIL midstart_ovf got=%b want=0", bus.trace_overflow); end
  endtask

  task automatic test_random();
    idle_inputs(); do_start();
    for (int c = 0; c < 600; c++) begin
      bus.start     = ($urandom_range(0, 59) == 0);
      bus.cpu_pc    = 18'($urandom_range(0, 2));
      bus.cpu_state = ($urandom_range(0, 2) == 0) ? 3'd4 : (($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7)));
      bus.mem_write = ($urandom_range(0, 2) == 0);
      bus.mem_addr  = 18'($urandom);
      bus.mem_wdata = 18'($urandom);
      bus.trace_pop = ($urandom_range(0, 3) == 0);
      step();
      n_checks += 5;
      if (bus.dbg_state !== mon_state_t'(m_state)) begin n_errors++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, bus.dbg_state, m_state); end
      if (bus.cycle_count !== 32'(m_cycles)) begin n_errors++; $display("FAIL rnd_cycle c=%0d got=%0d want=%0d", c, bus.cycle_count, m_cycles); end
      if (bus.instr_count !== 32'(m_instr)) begin n_errors++; $display("FAIL rnd_instr c=%0d got=%0d want=%0d", c, bus.instr_count, m_instr); end
      if (bus.trace_overflow !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, bus.trace_overflow, m_ovf); end
      if (bus.trace_valid !== (exp_q.size() > 0)) begin n_errors++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, bus.trace_valid, exp_q.size() > 0); end
      else if (exp_q.size() > 0) begin
        n_checks++;
        if ({bus.trace_addr, bus.trace_data} !== exp_q[0]) begin
          n_errors++; $display("FAIL rnd_head c=%0d got=%h want=%h", c, {bus.trace_addr, bus.trace_data}, exp_q[0]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_halt();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_reset_start_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
